// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, stall hold, flush-to-bubble, saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a 1-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign accept    = in_valid & in_ready;
    assign out_data  = data_q;
    assign stall_cnt = cnt_q;

    // Counts against the main register only; flush does not clear it.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && !out_ready) cnt_d = sat_inc(cnt_q);
    end

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != EMPTY);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            data_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        data_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && !out_ready) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (accept) begin
                        data_d = in_data;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                        data_d  = NOP_VALUE;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state_d = ONE;
                        data_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    data_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
        // Registered ready: decided from the next state so no path runs from out_ready.
        rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic valid_q, valid_d;
    logic drain;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign drain     = valid_q & out_ready;

    // Flush wins over accept; accept with drain replaces the payload in place.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (drain) begin
            valid_d = 1'b0;
            data_d  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based occupancy model checked every cycle plus directed literal checks.
// Two instances share stimulus: WIDTH=64/CNT_W=16 and WIDTH=8/CNT_W=2 (saturation).
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;
    logic        in_ready2, out_valid2;
    logic [7:0]  out_data2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    pipe_stage_reg #(.WIDTH(64), .NOP_VALUE(64'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .stall_cnt(stall_cnt));

    pipe_stage_reg #(.WIDTH(8), .NOP_VALUE(8'h0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data[7:0]), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .stall_cnt(stall_cnt2));

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // Model: the stage is a FIFO of capacity CAP; the head is what is presented downstream.
    logic [63:0] mq[$];
    int          mcnt, mcnt2;
    bit          m_acc, m_drn;

    function automatic bit model_ready();
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic logic [63:0] model_head();
        return (mq.size() > 0) ? mq[0] : 64'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mcnt  = 0;
            mcnt2 = 0;
        end else begin
            m_acc = in_valid && model_ready();
            m_drn = (mq.size() > 0) && out_ready;
            if (mq.size() > 0 && !out_ready) begin
                if (mcnt < 65535) mcnt++;
                if (mcnt2 < 3) mcnt2++;
            end
            if (flush) mq.delete();
            else begin
                if (m_drn) void'(mq.pop_front());
                if (m_acc) mq.push_back(in_data);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_in_ready",   64'(in_ready),   64'(model_ready()));
            chk("m_out_valid",  64'(out_valid),  64'(mq.size() > 0));
            chk("m_out_data",   out_data,        model_head());
            chk("m_stall_cnt",  64'(stall_cnt),  64'(mcnt));
            chk("m_in_ready2",  64'(in_ready2),  64'(model_ready()));
            chk("m_out_valid2", 64'(out_valid2), 64'(mq.size() > 0));
            chk("m_out_data2",  64'(out_data2),  64'(model_head() & 64'hFF));
            chk("m_stall_cnt2", 64'(stall_cnt2), 64'(mcnt2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp5[6] = '{1, 2, 3, 3, 3, 3};
    bit hold_rdy;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1;

        // Reset then idle.
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Streaming with full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            tick();
            chk("stream_data", out_data, 64'(i));
            chk("stream_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(out_valid), 64'd0);
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Stall hold for 5 cycles.
`ifdef PIPE_STAGE_SKID_EN
        hold_rdy = 1'b1;
`else
        hold_rdy = 1'b0;
`endif
        in_valid = 1'b1; in_data = 64'hAA;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_data", out_data, 64'hAA);
            chk("hold_in_ready", 64'(in_ready), 64'(hold_rdy));
        end
        chk("hold_stall5", 64'(stall_cnt), 64'd5);
        out_ready = 1'b1;
        tick();
        chk("hold_drain", 64'(out_valid), 64'd0);
        chk("hold_stall_kept", 64'(stall_cnt), 64'd5);

        // Flush beats accept; flush does not touch the counter.
        in_valid = 1'b1; in_data = 64'h33; out_ready = 1'b0;
        tick();
        flush = 1'b1; in_data = 64'h55;
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", out_data, 64'd0);
        chk("flush_stall", 64'(stall_cnt), 64'd6);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_no55", out_data, 64'd0);
        flush = 1'b1; in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b1;
        tick();
        chk("flush_idle_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset in the middle of a transfer.
        in_valid = 1'b1; in_data = 64'h77; out_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", out_data, 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();

        // Saturation on the CNT_W=2 instance.
        in_valid = 1'b1; in_data = 64'h9; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat_cnt2", 64'(stall_cnt2), 64'(exp5[i]));
            chk("sat_cnt16", 64'(stall_cnt), 64'(i + 1));
        end
        out_ready = 1'b1;
        tick();

`ifdef PIPE_STAGE_SKID_EN
        // Skid: fill to two entries, drain in order, then flush from full.
        in_valid = 1'b1; in_data = 64'h1; out_ready = 1'b0;
        tick();
        chk("skid_rdy_one", 64'(in_ready), 64'd1);
        in_data = 64'h2;
        tick();
        chk("skid_rdy_two", 64'(in_ready), 64'd0);
        chk("skid_head1", out_data, 64'h1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid_head2", out_data, 64'h2);
        chk("skid_rdy_back", 64'(in_ready), 64'd1);
        tick();
        chk("skid_empty", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_data = 64'h3; out_ready = 1'b0;
        tick();
        in_data = 64'h4;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("skid_flush_valid", 64'(out_valid), 64'd0);
        chk("skid_flush_rdy", 64'(in_ready), 64'd1);
        tick();
`endif

        // Mixed traffic pattern.
        for (int i = 0; i < 24; i++) begin
            in_valid  = (i % 3) != 0;
            in_data   = 64'hC0DE_0000 + 64'(i);
            out_ready = (i % 4) < 2;
            flush     = (i == 17);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
